// File: rtl/float_encode_seq.sv
// Unsigned integer to {E,M} float encoder with a one-shift-per-clock normaliser.
// Define FLOAT_ENCODE_ROUND_EN for round-half-up with saturation; default build truncates.
//
// state | meaning
// IDLE  | in_ready high, waiting for in_valid
// SHIFT | right-shifting until the value fits the mantissa
// DONE  | out_valid high, holding out_data until out_ready
module float_encode_seq #(
    parameter int EXP_WIDTH = 3,
    parameter int MAN_WIDTH = 5,
    parameter int IN_WIDTH  = 12
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [IN_WIDTH-1:0]            in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [EXP_WIDTH+MAN_WIDTH-1:0] out_data,
    output logic                           out_valid,
    input  logic                           out_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                         state_q,    state_d;
    logic [IN_WIDTH-1:0]            shift_q,    shift_d;
    logic [EXP_WIDTH-1:0]           exp_q,      exp_d;
    logic [EXP_WIDTH+MAN_WIDTH-1:0] out_data_q, out_data_d;
    logic                           out_valid_q, out_valid_d;
    logic                           norm_done;
    logic [EXP_WIDTH+MAN_WIDTH-1:0] enc;

`ifdef FLOAT_ENCODE_ROUND_EN
    logic                 guard_q, guard_d;
    logic [MAN_WIDTH:0]   man_rnd;
    logic [EXP_WIDTH-1:0] exp_inc;
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

    // Value fits once nothing remains above the mantissa field.
    assign norm_done = (shift_q[IN_WIDTH-1:MAN_WIDTH] == '0);

`ifdef FLOAT_ENCODE_ROUND_EN
    // Mantissa overflow renormalises to 100..0 and bumps E; at max E it saturates.
    always_comb begin
        man_rnd = {1'b0, shift_q[MAN_WIDTH-1:0]} + (MAN_WIDTH+1)'(guard_q);
        exp_inc = exp_q + EXP_WIDTH'(1);
        enc     = {exp_q, man_rnd[MAN_WIDTH-1:0]};
        if (man_rnd[MAN_WIDTH]) begin
            if (exp_q == '1) begin
                enc = '1;
            end else begin
                enc = {exp_inc, 1'b1, {(MAN_WIDTH-1){1'b0}}};
            end
        end
    end
`else
    assign enc = {exp_q, shift_q[MAN_WIDTH-1:0]};
`endif

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        exp_d       = exp_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
`ifdef FLOAT_ENCODE_ROUND_EN
        guard_d     = guard_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shift_d = in_data;
                    exp_d   = '0;
`ifdef FLOAT_ENCODE_ROUND_EN
                    guard_d = 1'b0;
`endif
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!norm_done) begin
                    shift_d = shift_q >> 1;
                    exp_d   = exp_q + EXP_WIDTH'(1);
`ifdef FLOAT_ENCODE_ROUND_EN
                    guard_d = shift_q[0];
`endif
                end else begin
                    out_data_d  = enc;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            exp_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
`ifdef FLOAT_ENCODE_ROUND_EN
            guard_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            exp_q       <= exp_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
`ifdef FLOAT_ENCODE_ROUND_EN
            guard_q     <= guard_d;
`endif
        end
    end

endmodule

// File: tb/tb_float_encode_seq.sv
// Self-checking bench for float_encode_seq: vector table, model-driven random
// inputs, and hand sequences for stall, back-to-back and mid-conversion reset.
module tb_float_encode_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;

    always #5 clk = ~clk;

    float_encode_seq #(
        .EXP_WIDTH(3),
        .MAN_WIDTH(5),
        .IN_WIDTH (12)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] sb_q[$];

    typedef struct {
        logic [11:0] din;
        logic [7:0]  dout;
        int          k;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: count shifts by magnitude, then apply the rounding rule arithmetically.
    function automatic logic [7:0] model(input int v, output int k);
        int m, e, g;
        k = 0;
        while ((v >> k) > 31) k++;
        m = v >> k;
        e = k;
`ifdef FLOAT_ENCODE_ROUND_EN
        g = (k > 0) ? ((v >> (k - 1)) & 1) : 0;
        m = m + g;
        if (m == 32) begin
            if (e == 7) return 8'hFF;
            m = 16;
            e = e + 1;
        end
`else
        g = 0;
`endif
        return {e[2:0], m[4:0]} | 8'(g & 0);
    endfunction

    task automatic pop_chk(input string name);
        logic [7:0] exp_v;
        if (sb_q.size() == 0) begin
            chk({name, "_sb_empty"}, 0, 1);
        end else begin
            exp_v = sb_q.pop_front();
            chk(name, out_data, exp_v);
        end
    endtask

    // Called #1 after a posedge with the DUT idle.
    task automatic do_conv(input logic [11:0] din, input logic [7:0] expv, input int k,
                           input int stall);
        int n;
        in_valid = 1'b1;
        in_data  = din;
        sb_q.push_back(expv);
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_wait", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("out_valid_wait", out_valid, 1);
        if (out_valid) begin
            pop_chk("out_data");
            chk("latency", n, k + 2);
        end
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            in_data  = 12'h005;
            @(posedge clk); #1;
            chk("stall_data", out_data, expv);
            chk("stall_valid", out_valid, 1);
            chk("stall_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("done_valid_clr", out_valid, 0);
        chk("done_in_ready", in_ready, 1);
        if (stall > 0) begin
            repeat (3) @(posedge clk);
            #1;
            chk("ignored_input", out_valid, 0);
        end
    endtask

    initial begin
        int kk;
        int v;
        logic [7:0] ev;
        int e_idx;
        int nacc, nout;
        int acc_e[2];
        int outv_e[2];
        logic will_acc;

        vecs[0] = '{12'd0,    8'h00, 0};
        vecs[1] = '{12'd31,   8'h1F, 0};
        vecs[2] = '{12'd32,   8'h30, 1};
        vecs[3] = '{12'd100,  8'h59, 2};
        vecs[4] = '{12'd1,    8'h01, 0};
        vecs[5] = '{12'd50,   8'h39, 1};
        vecs[6] = '{12'd2048, 8'hF0, 7};
`ifdef FLOAT_ENCODE_ROUND_EN
        vecs[7] = '{12'd63,   8'h50, 1};
        vecs[8] = '{12'd2047, 8'hF0, 6};
`else
        vecs[7] = '{12'd63,   8'h3F, 1};
        vecs[8] = '{12'd2047, 8'hDF, 6};
`endif

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", in_ready, 1);

        for (int i = 0; i < 9; i++) begin
            do_conv(vecs[i].din, vecs[i].dout, vecs[i].k, 0);
        end

        for (int i = 0; i < 6; i++) begin
            v  = int'($urandom_range(0, 4095));
            ev = model(v, kk);
            do_conv(12'(v), ev, kk, 0);
        end

        // Maximum input, held for three stalled cycles with a stray in_valid.
        do_conv(12'd4095, 8'hFF, 7, 3);

        // Back-to-back with out_ready tied high and in_valid held.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 12'd5;
        sb_q.push_back(8'h05);
        sb_q.push_back(8'h50);
        nacc = 0;
        nout = 0;
        acc_e[0] = 0; acc_e[1] = 0;
        outv_e[0] = 0; outv_e[1] = 0;
        for (e_idx = 0; e_idx < 40 && nout < 2; e_idx++) begin
            @(negedge clk);
            will_acc = in_ready && in_valid;
            @(posedge clk); #1;
            if (will_acc && nacc < 2) begin
                acc_e[nacc] = e_idx;
                nacc++;
                if (nacc == 1) in_data = 12'd64;
                else           in_valid = 1'b0;
            end
            if (out_valid && nout < 2) begin
                outv_e[nout] = e_idx;
                nout++;
                pop_chk("b2b_data");
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("b2b_outputs", nout, 2);
        chk("b2b_idle_gap", acc_e[1] - outv_e[0], 2);
        @(posedge clk); #1;

        // Reset while shifting 4095.
        in_valid = 1'b1;
        in_data  = 12'd4095;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_busy", in_ready, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_data", out_data, 0);
        chk("midrst_in_ready", in_ready, 1);
        repeat (10) @(posedge clk);
        #1;
        chk("midrst_discarded", out_valid, 0);
        do_conv(12'd7, 8'h07, 0, 0);

        chk("sb_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
